// File: rtl/puf_window_timer_pkg.sv
// Shared types for the PUF measurement-window timer.
// State encoding and MODE values.
package puf_window_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_STOP = 2'd3
  } state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/puf_cnt.sv
// WIDTH-bit cycle counter: async reset, sync clear, load-zero, enable.
// Ports: clk, arst_n, clr, load0, en in; q out. Priority clr > load0 > en.
module puf_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             clr,
  input  logic             load0,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (load0) begin
      q_d = '0;
    end else if (en) begin
      q_d = q_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) q_q <= '0;
    else         q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/puf_window_timer.sv
// Measurement-window timer: gates RO counters for TC cycles, DONE pulse,
// sticky TIME_STOP, one-shot/reload modes and a completed-window count.
module puf_window_timer
  import puf_window_timer_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int WCNT_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  ARESETN,
  input  logic                  SCLR,
  input  logic                  CE,
  input  logic                  START,
  input  logic                  MODE,
  input  logic [WIDTH-1:0]      TC,
  output logic [WIDTH-1:0]      Q,
  output logic                  WINDOW,
  output logic                  DONE,
  output logic                  TIME_STOP,
  output logic [WCNT_WIDTH-1:0] WIN_CNT
);

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      tc_q, tc_d;
  logic                  mode_q, mode_d;
  logic                  done_q, done_d;
  logic [WCNT_WIDTH-1:0] wcnt_q, wcnt_d;
  logic                  cnt_ld0;
  logic                  cnt_en;
  logic [WIDTH-1:0]      tc_last;

  // tc_q is never zero while in RUN, so tc_q-1 cannot underflow there.
  assign tc_last = tc_q - WIDTH'(1);

  always_comb begin
    state_d = state_q;
    tc_d    = tc_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    wcnt_d  = wcnt_q;
    cnt_ld0 = 1'b0;
    cnt_en  = 1'b0;
    if (SCLR) begin
      state_d = ST_IDLE;
      tc_d    = '0;
      mode_d  = MODE_ONESHOT;
      wcnt_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_STOP: begin
          if (START) begin
            cnt_ld0 = 1'b1;
            if (TC != '0) begin
              tc_d    = TC;
              mode_d  = MODE;
              state_d = ST_RUN;
            end else begin
              // Zero-length window: complete at once, nothing counted.
              tc_d    = '0;
              done_d  = 1'b1;
              state_d = ST_STOP;
            end
          end
        end
        ST_RUN: begin
          if (CE) begin
            cnt_en = 1'b1;
            if (Q == tc_last) begin
              done_d  = 1'b1;
              wcnt_d  = wcnt_q + WCNT_WIDTH'(1);
              state_d = (mode_q == MODE_RELOAD) ? ST_GAP : ST_STOP;
            end
          end
        end
        ST_GAP: begin
          cnt_ld0 = 1'b1;
          state_d = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= ST_IDLE;
      tc_q    <= '0;
      mode_q  <= MODE_ONESHOT;
      done_q  <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      wcnt_q  <= wcnt_d;
    end
  end

  puf_cnt #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk   (CLK),
    .arst_n(ARESETN),
    .clr   (SCLR),
    .load0 (cnt_ld0),
    .en    (cnt_en),
    .q     (Q)
  );

  assign WINDOW    = (state_q == ST_RUN);
  assign TIME_STOP = (state_q == ST_STOP);
  assign DONE      = done_q;
  assign WIN_CNT   = wcnt_q;

endmodule

// File: tb/tb_puf_window_timer.sv
// Directed + random bench for puf_window_timer against a behavioural model.
// WIDTH=8, WCNT_WIDTH=4 so TC=255 and WIN_CNT wrap are reachable.
module tb_puf_window_timer;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          ARESETN;
  logic          SCLR;
  logic          CE;
  logic          START;
  logic          MODE;
  logic [W-1:0]  TC;
  logic [W-1:0]  Q;
  logic          WINDOW;
  logic          DONE;
  logic          TIME_STOP;
  logic [CW-1:0] WIN_CNT;

  puf_window_timer #(
    .WIDTH     (W),
    .WCNT_WIDTH(CW)
  ) dut (
    .CLK      (CLK),
    .ARESETN  (ARESETN),
    .SCLR     (SCLR),
    .CE       (CE),
    .START    (START),
    .MODE     (MODE),
    .TC       (TC),
    .Q        (Q),
    .WINDOW   (WINDOW),
    .DONE     (DONE),
    .TIME_STOP(TIME_STOP),
    .WIN_CNT  (WIN_CNT)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Behavioural model: phase of the timer and its observable values.
  typedef enum int {P_IDLE, P_RUN, P_GAP, P_STOP} phase_e;
  phase_e m_ph;
  int     m_q, m_tc, m_mode, m_done, m_wcnt;
  logic   prev_done;
  int     win_hi;

  task automatic model_reset();
    m_ph = P_IDLE; m_q = 0; m_tc = 0;
    m_mode = 0; m_done = 0; m_wcnt = 0;
  endtask

  task automatic model_step();
    if (!ARESETN || SCLR) begin
      model_reset();
    end else begin
      m_done = 0;
      case (m_ph)
        P_IDLE, P_STOP: if (START) begin
          m_q = 0;
          if (TC != 0) begin
            m_tc = int'(TC); m_mode = int'(MODE); m_ph = P_RUN;
          end else begin
            m_tc = 0; m_done = 1; m_ph = P_STOP;
          end
        end
        P_RUN: if (CE) begin
          m_q = m_q + 1;
          if (m_q == m_tc) begin
            m_done = 1;
            m_wcnt = (m_wcnt + 1) % (1 << CW);
            m_ph = m_mode ? P_GAP : P_STOP;
          end
        end
        P_GAP: begin
          m_q = 0; m_ph = P_RUN;
        end
        default: ;
      endcase
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("Q", 32'(Q), 32'(m_q));
    chk("WINDOW", 32'(WINDOW), 32'(m_ph == P_RUN));
    chk("DONE", 32'(DONE), 32'(m_done));
    chk("TIME_STOP", 32'(TIME_STOP), 32'(m_ph == P_STOP));
    chk("WIN_CNT", 32'(WIN_CNT), 32'(m_wcnt));
    chk("DONE_TWICE", 32'(prev_done & DONE), 32'd0);
    prev_done = DONE;
    if (WINDOW === 1'b1) win_hi++;
  endtask

  task automatic cyc(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      model_step();
      #1;
      check_all();
    end
  endtask

  task automatic start_win(int tc, logic md);
    TC = W'(tc); MODE = md; START = 1'b1;
    cyc();
    START = 1'b0;
  endtask

  initial begin
    ARESETN = 1'b0; SCLR = 1'b0; CE = 1'b0;
    START = 1'b0; MODE = 1'b0; TC = '0;
    prev_done = 1'b0; win_hi = 0;
    model_reset();
    #1;
    check_all();
    cyc(2);
    ARESETN = 1'b1;
    cyc(2);

    // 1: one-shot TC=10, then 25 more cycles with CE=1
    CE = 1'b1;
    win_hi = 0;
    start_win(10, 1'b0);
    cyc(35);
    chk("T1_WIN_LEN", 32'(win_hi), 32'd10);
    chk("T1_Q_FROZEN", 32'(Q), 32'd10);
    chk("T1_WCNT", 32'(WIN_CNT), 32'd1);

    // 2: re-arm from STOP, pause 5 cycles at Q=4
    win_hi = 0;
    start_win(10, 1'b0);
    cyc(4);
    chk("T2_Q_AT_PAUSE", 32'(Q), 32'd4);
    CE = 1'b0;
    cyc(5);
    chk("T2_Q_HELD", 32'(Q), 32'd4);
    CE = 1'b1;
    cyc(10);
    chk("T2_WIN_LEN", 32'(win_hi), 32'd15);
    chk("T2_WCNT", 32'(WIN_CNT), 32'd2);

    // 3: reload TC=3 for 20 cycles, then SCLR
    SCLR = 1'b1; cyc(); SCLR = 1'b0;
    start_win(3, 1'b1);
    cyc(20);
    chk("T3_WCNT", 32'(WIN_CNT), 32'd5);
    SCLR = 1'b1; cyc(); SCLR = 1'b0;
    chk("T3_CLR_Q", 32'(Q), 32'd0);
    chk("T3_CLR_WCNT", 32'(WIN_CNT), 32'd0);

    // 4: SCLR+START in STOP drops START, then START with TC=5
    start_win(2, 1'b0);
    cyc(3);
    SCLR = 1'b1; START = 1'b1; TC = 8'd7;
    cyc();
    SCLR = 1'b0; START = 1'b0;
    chk("T4_TSTOP", 32'(TIME_STOP), 32'd0);
    chk("T4_WINDOW", 32'(WINDOW), 32'd0);
    cyc();
    start_win(5, 1'b0);
    cyc(6);
    chk("T4_Q", 32'(Q), 32'd5);

    // 5: TC=0 from IDLE
    SCLR = 1'b1; cyc(); SCLR = 1'b0;
    start_win(0, 1'b1);
    chk("T5_DONE", 32'(DONE), 32'd1);
    chk("T5_TSTOP", 32'(TIME_STOP), 32'd1);
    cyc(3);

    // TC=255 boundary, TC=1 reload
    start_win(255, 1'b0);
    cyc(256);
    chk("TMAX_Q", 32'(Q), 32'd255);
    start_win(1, 1'b1);
    cyc(12);

    // 6: async reset mid-window at Q=6
    SCLR = 1'b1; cyc(); SCLR = 1'b0;
    start_win(10, 1'b0);
    cyc(6);
    #3;
    ARESETN = 1'b0;
    #1;
    model_reset();
    check_all();
    cyc(2);
    #2;
    ARESETN = 1'b1;
    cyc(4);
    chk("T6_IDLE", 32'(WINDOW | TIME_STOP), 32'd0);

    // Random stimulus against the model
    for (int i = 0; i < 600; i++) begin
      SCLR  = ($urandom_range(0, 49) == 0);
      START = ($urandom_range(0, 5) == 0);
      CE    = ($urandom_range(0, 3) != 0);
      MODE  = 1'($urandom_range(0, 1));
      TC    = ($urandom_range(0, 19) == 0) ? 8'd255
            : W'($urandom_range(0, 6));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
